// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the fully_connected layer:
// controller state encoding, accumulator sizing, saturation and ReLU.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } fc_state_e;

  // Helpers work at a fixed maximum width; callers sign-extend in and slice out.
  localparam int unsigned MAX_WORD_W = 32;
  localparam int unsigned MAX_ACC_W  = 2 * MAX_WORD_W + 32;

  function automatic int unsigned fc_acc_width(input int unsigned word_size,
                                               input int unsigned n_inputs);
    return 2 * word_size + $clog2(n_inputs) + 1;
  endfunction

  function automatic logic signed [MAX_WORD_W-1:0] fc_sat(
      input logic signed [MAX_ACC_W-1:0] v,
      input int unsigned                 word_size);
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    hi = MAX_ACC_W'(1);
    hi = (hi <<< (word_size - 1)) - MAX_ACC_W'(1);
    lo = ~hi;
    if (v > hi) begin
      return hi[MAX_WORD_W-1:0];
    end else if (v < lo) begin
      return lo[MAX_WORD_W-1:0];
    end
    return v[MAX_WORD_W-1:0];
  endfunction

  function automatic logic signed [MAX_WORD_W-1:0] fc_relu(
      input logic signed [MAX_WORD_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/fully_connected_if.sv
// Operand/result bus of the fully_connected layer with start/busy/done handshake.
interface fully_connected_if #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned IP_LAYER_SIZE = 128,
    parameter int unsigned OP_LAYER_SIZE = 84
);

    logic                        start;
    logic signed [WORD_SIZE-1:0] X [IP_LAYER_SIZE];
    logic signed [WORD_SIZE-1:0] W [OP_LAYER_SIZE][IP_LAYER_SIZE];
    logic signed [WORD_SIZE-1:0] B [OP_LAYER_SIZE];
    logic signed [WORD_SIZE-1:0] Z [OP_LAYER_SIZE];
    logic                        busy;
    logic                        done;

    modport master (output start, X, W, B, input Z, busy, done);
    modport slave  (input start, X, W, B, output Z, busy, done);

endinterface

// File: rtl/fc_mac.sv
// One output-neuron lane: bias load, signed MAC, saturating (optionally ReLU,
// when FC_RELU_EN is defined) registered output.
module fc_mac
  import fc_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned IP_LAYER_SIZE = 128,
    parameter int unsigned FRAC_BITS     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        acc_en,
    input  logic                        out_en,
    input  logic signed [WORD_SIZE-1:0] bias,
    input  logic signed [WORD_SIZE-1:0] weight,
    input  logic signed [WORD_SIZE-1:0] x,
    output logic signed [WORD_SIZE-1:0] z
);

    localparam int unsigned ACC_W = fc_acc_width(WORD_SIZE, IP_LAYER_SIZE);

    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       shifted;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [MAX_WORD_W-1:0]  clamped;
    logic                          clamp_unused;

    assign prod    = weight * x;
    assign shifted = acc >>> FRAC_BITS;

    always_comb begin
        clamped = fc_sat(MAX_ACC_W'(shifted), WORD_SIZE);
`ifdef FC_RELU_EN
        clamped = fc_relu(clamped);
`endif
    end

    // After saturation the upper bits are pure sign extension.
    assign clamp_unused = ^clamped[MAX_WORD_W-1:WORD_SIZE];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            z   <= '0;
        end else begin
            if (load) begin
                acc <= ACC_W'(bias) <<< FRAC_BITS;
            end else if (acc_en) begin
                acc <= acc + ACC_W'(prod);
            end
            if (out_en) begin
                z <= clamped[WORD_SIZE-1:0];
            end
        end
    end

endmodule

// File: rtl/fully_connected.sv
// Dense layer Z[j] = sum_i W[j][i]*X[i] + B[j]: one input index per cycle,
// all output lanes in parallel. Optional ReLU output via FC_RELU_EN.
module fully_connected
  import fc_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned IP_LAYER_SIZE = 128,
    parameter int unsigned OP_LAYER_SIZE = 84,
    parameter int unsigned FRAC_BITS     = 8
) (
    input logic              clk,
    input logic              reset,
    fully_connected_if.slave bus
);

    localparam int unsigned IDX_W = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1;

    fc_state_e              state, state_next;
    logic [IDX_W-1:0]       idx;
    logic                   load, acc_en, out_en, last, done;

    assign last = (idx == IDX_W'(IP_LAYER_SIZE - 1));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        acc_en     = 1'b0;
        out_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                acc_en = 1'b1;
                if (last) state_next = OUT;
            end
            OUT: begin
                out_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= out_en;
            if (load) begin
                idx <= '0;
            end else if (acc_en && !last) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done;

    for (genvar j = 0; j < OP_LAYER_SIZE; j++) begin : g_lane
        fc_mac #(
            .WORD_SIZE    (WORD_SIZE),
            .IP_LAYER_SIZE(IP_LAYER_SIZE),
            .FRAC_BITS    (FRAC_BITS)
        ) u_mac (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .acc_en(acc_en),
            .out_en(out_en),
            .bias  (bus.B[j]),
            .weight(bus.W[j][idx]),
            .x     (bus.X[idx]),
            .z     (bus.Z[j])
        );
    end

endmodule

// File: tb/tb_fully_connected.sv
// Scoreboard bench for fully_connected: reference results queued at start,
// compared at each done pulse. Honours FC_RELU_EN like the design.
module tb_fully_connected;

    localparam int unsigned WS = 16;
    localparam int unsigned IP = 128;
    localparam int unsigned OP = 84;
    localparam int unsigned FB = 8;

    typedef logic [WS*OP-1:0] zvec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fully_connected_if #(.WORD_SIZE(WS), .IP_LAYER_SIZE(IP), .OP_LAYER_SIZE(OP)) bus ();

    fully_connected #(
        .WORD_SIZE    (WS),
        .IP_LAYER_SIZE(IP),
        .OP_LAYER_SIZE(OP),
        .FRAC_BITS    (FB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_done   = 0;
    logic  prev_done = 1'b0;
    zvec_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic zvec_t model();
        zvec_t v;
        v = '0;
        for (int j = 0; j < OP; j++) begin
            longint acc;
            acc = longint'(bus.B[j]) * 256;
            for (int i = 0; i < IP; i++) begin
                acc += longint'(bus.W[j][i]) * longint'(bus.X[i]);
            end
            acc = acc >>> FB;
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
            if (acc < 0) acc = 0;
`endif
            v[j*WS +: WS] = acc[WS-1:0];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (bus.done) begin
            n_done++;
            check("done_width", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                zvec_t          e;
                logic [WS-1:0]  zg;
                e = exp_q.pop_front();
                for (int j = 0; j < OP; j++) begin
                    zg = bus.Z[j];
                    check($sformatf("z[%0d]", j), 64'(zg), 64'(e[j*WS +: WS]));
                end
            end
        end
        prev_done = bus.done;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ops(input logic [WS-1:0] xv, input logic [WS-1:0] wv, input logic [WS-1:0] bv);
        for (int i = 0; i < IP; i++) bus.X[i] = xv;
        for (int j = 0; j < OP; j++) begin
            bus.B[j] = bv;
            for (int i = 0; i < IP; i++) bus.W[j][i] = wv;
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < IP; i++) bus.X[i] = WS'($urandom_range(0, 1023)) - WS'(512);
        for (int j = 0; j < OP; j++) begin
            bus.B[j] = WS'($urandom_range(0, 4095)) - WS'(2048);
            for (int i = 0; i < IP; i++) bus.W[j][i] = WS'($urandom_range(0, 1023)) - WS'(512);
        end
    endtask

    task automatic launch();
        exp_q.push_back(model());
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input bit chk_busy);
        int cnt;
        cnt = bus.busy ? 1 : 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.done) break;
            @(posedge clk);
            #1;
            if (bus.busy) cnt++;
        end
        if (!bus.done) check("done_timeout", 64'd0, 64'd1);
        if (chk_busy) check("busy_cycles", 64'(cnt), 64'(IP + 1));
    endtask

    initial begin
        int            d0;
        logic [WS-1:0] zg;
        bus.start = 1'b0;
        set_ops('0, '0, '0);
        reset = 1'b1;
        idle(3);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        for (int j = 0; j < OP; j++) begin
            zg = bus.Z[j];
            check("rst_z", 64'(zg), 64'd0);
        end
        reset = 1'b0;
        idle(1);

        // bias only
        for (int j = 0; j < OP; j++) bus.B[j] = WS'(j * 256);
        launch();
        wait_done(1'b1);
        zg = bus.Z[OP-1];
        check("bias_z83", 64'(zg), 64'h5300);
        idle(2);

        // 128 * 1.0 * 0.5 = 64.0
        set_ops(16'h0100, 16'h0080, 16'h0000);
        launch();
        wait_done(1'b1);
        zg = bus.Z[5];
        check("half_z5", 64'(zg), 64'h4000);
        idle(1);

        // positive saturation, then back-to-back negative saturation
        set_ops(16'h7FFF, 16'h7FFF, 16'h0000);
        launch();
        wait_done(1'b1);
        zg = bus.Z[0];
        check("sat_pos", 64'(zg), 64'h7FFF);
        set_ops(16'h7FFF, 16'h8000, 16'h0000);
        launch();
        wait_done(1'b1);
        zg = bus.Z[OP-1];
`ifdef FC_RELU_EN
        check("sat_neg", 64'(zg), 64'h0000);
`else
        check("sat_neg", 64'(zg), 64'h8000);
`endif
        idle(1);

        // single negative product
        set_ops('0, '0, '0);
        bus.X[0] = 16'h0100;
        for (int j = 0; j < OP; j++) bus.W[j][0] = 16'hFF00;
        launch();
        wait_done(1'b1);
        zg = bus.Z[10];
`ifdef FC_RELU_EN
        check("sign_z10", 64'(zg), 64'h0000);
`else
        check("sign_z10", 64'(zg), 64'hFF00);
`endif
        idle(1);

        for (int r = 0; r < 2; r++) begin
            set_random();
            launch();
            wait_done(1'b1);
            idle(1);
        end

        // abort by reset 50 cycles into a computation
        set_random();
        launch();
        idle(49);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        for (int j = 0; j < OP; j++) begin
            zg = bus.Z[j];
            check("abort_z", 64'(zg), 64'd0);
        end
        void'(exp_q.pop_back());
        d0 = n_done;
        idle(140);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        launch();
        wait_done(1'b1);
        idle(1);

        // start while busy with changed bias is ignored
        set_random();
        d0 = n_done;
        launch();
        idle(20);
        for (int j = 0; j < OP; j++) bus.B[j] = 16'h1234;
        bus.start = 1'b1;
        idle(1);
        bus.start = 1'b0;
        wait_done(1'b0);
        idle(140);
        check("single_done", 64'(n_done - d0), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fully_connected.md
# fully_connected

Fully connected (dense) neural-network layer for the CNN datapath: computes Z[j] = sum over i of W[j][i]·X[i] + B[j] for every output neuron, in signed fixed point. It sits after the flattened convolution/pooling stage (128 inputs → 84 outputs by default) and feeds the next dense or classifier stage. Computation is sequential over the input index, with all output neurons accumulated in parallel, under a start/done handshake.

## Interface
- WORD_SIZE, 16, width of every data, weight, bias and output word (signed two's complement)
- IP_LAYER_SIZE, 128, number of input neurons
- OP_LAYER_SIZE, 84, number of output neurons
- FRAC_BITS, 8, fractional bits of the fixed-point format (default Q8.8)
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to compute; sampled only in IDLE
- X  in  WORD_SIZE × [IP_LAYER_SIZE]  input vector; must stay stable while busy
- W  in  WORD_SIZE × [OP_LAYER_SIZE][IP_LAYER_SIZE]  weight matrix; must stay stable while busy
- B  in  WORD_SIZE × [OP_LAYER_SIZE]  bias vector; must stay stable while busy
- Z  out  WORD_SIZE × [OP_LAYER_SIZE]  registered output vector
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse when Z has been updated

## Operation
- Three states: IDLE, ACC, OUT.
- IDLE: when start=1, load acc[j] with sign-extended B[j] shifted left by FRAC_BITS, clear idx, go to ACC, and set busy=1.
- ACC: each cycle, acc[j] += W[j][idx]·X[idx] for all j in parallel (signed full-precision product). When idx = IP_LAYER_SIZE−1, go to OUT; otherwise increment idx.
- OUT: Z[j] ← sat(acc[j] >>> FRAC_BITS). The shift is arithmetic, so it floors toward −∞. Set done=1, set busy=0, and return to IDLE.
- Accumulator width is 2·WORD_SIZE + $clog2(IP_LAYER_SIZE) + 1, so no internal overflow occurs.
- sat clamps to the range [−2^(WORD_SIZE−1), 2^(WORD_SIZE−1)−1].
- start is ignored while busy. Z holds its value between done pulses.

## Timing
- start is sampled at edge T0. MACs occur at edges T1 … T_IP. Z is updated and done rises at edge T_IP+1. Total latency is IP_LAYER_SIZE+1 cycles; busy is high for exactly IP_LAYER_SIZE+1 cycles.
- Back-to-back: start may be asserted in the cycle where done=1, which begins a new computation at the next edge.
- Reset values: Z all 0, done 0, busy 0, state IDLE, acc all 0, idx 0.
- Reset asserted mid-computation aborts the computation at that edge: Z is cleared and no done pulse is produced.
- Reset has priority over start.

## Configuration
- FC_RELU_EN defined: the OUT stage applies ReLU after saturation, so negative results become 0.
- FC_RELU_EN undefined: the saturated signed value is output unchanged.

## Structure
- Shared package fc_pkg holds:
  - the state enum (IDLE/ACC/OUT),
  - the accumulator-width function/constant,
  - the saturate (and ReLU) function.
- One sub-module, fc_mac: a single signed multiply-accumulate lane with load, accumulate and saturating output. It is instantiated OP_LAYER_SIZE times under generate.
- The controller (FSM, idx counter, busy/done) lives in the top module.

## Test plan
- Zero weights, B[j] = j·0x0100 → after 129 cycles, Z[j] = j·0x0100; done high for exactly 1 cycle; busy high for 129 cycles.
- X all 0x0100 (1.0), W all 0x0080 (0.5), B all 0 → every Z[j] = 0x4000 (64.0).
- Saturation:
  - X all 0x7FFF, W all 0x7FFF → Z all 0x7FFF.
  - W all 0x8000 (without FC_RELU_EN) → Z all 0x8000.
- Sign/ReLU: X[0]=0x0100, W[j][0]=0xFF00, all other W and B 0:
  - without FC_RELU_EN → Z = 0xFF00;
  - with FC_RELU_EN → Z = 0x0000.
- Reset asserted 50 cycles after start → next edge: busy 0, Z 0, no done pulse. A following start completes normally with the correct Z.
- start pulsed while busy, with changed B → ignored; Z reflects the original operands, and only one done pulse occurs.
